// File: rtl/fifo_pkg.sv
// Shared defaults and FSM encoding for the FIFO write arbiter slice.
package fifo_pkg;
  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int ADDR_DEF  = 4;
  localparam int BURST_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first asserted request strictly after last_id, with wrap.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_id,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  int idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    // Offset 1..NREQ so last_id itself is considered last.
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_id) + i) % NREQ;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Multi-requester FIFO write arbiter: round-robin grants of up to BURST beats,
// credit-gated so the FIFO is never overrun.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ADDR  = ADDR_DEF,
  parameter int BURST = BURST_DEF,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fifo_writesig,
  output logic [WIDTH-1:0]      fifo_datain,
  input  logic                  fifo_full,
  input  logic [ADDR:0]         fifo_length,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  localparam int BW = $clog2(BURST) + 1;
  localparam logic [ADDR+1:0] DEPTH = (ADDR+2)'(1) << ADDR;

  arb_state_t       state;
  logic [IDW-1:0]   last_id;
  logic [BW-1:0]    beat_cnt;
  logic [BW-1:0]    beat_nxt;
  logic [IDW-1:0]   winner;
  logic             any_req;
  logic [ADDR+1:0]  free;
  logic             space;
  logic             xfer;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req_valid),
    .last_id (last_id),
    .winner  (winner),
    .any     (any_req)
  );

  // The in-flight registered write has not reached fifo_length yet, so it
  // is charged against credit here; a negative result also means no space.
  assign free  = DEPTH - (ADDR+2)'(fifo_length) - (ADDR+2)'(fifo_writesig);
  assign space = !fifo_full && (free != '0) && !free[ADDR+1];

  always_comb begin
    req_ready = '0;
    if (!rst && state == ST_GRANT)
      req_ready[grant_id] = space;
  end

  assign xfer     = (state == ST_GRANT) && req_valid[grant_id] && space;
  assign beat_nxt = beat_cnt + BW'(1);
  assign busy     = (state == ST_GRANT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      fifo_writesig <= 1'b0;
      fifo_datain   <= '0;
      grant_id      <= '0;
      last_id       <= IDW'(NREQ - 1);
      beat_cnt      <= '0;
    end else begin
      fifo_writesig <= xfer;
      if (xfer)
        fifo_datain <= req_data[int'(grant_id)*WIDTH +: WIDTH];
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_id <= winner;
            beat_cnt <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (xfer)
            beat_cnt <= beat_nxt;
          if ((xfer && beat_nxt == BW'(BURST)) || !req_valid[grant_id]) begin
            last_id <= grant_id;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter plus a short randomized FIFO-model run.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, WIDTH = 8, ADDR = 4, BURST = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_writesig;
  logic [WIDTH-1:0]      fifo_datain;
  logic                  fifo_full;
  logic [ADDR:0]         fifo_length;
  logic [1:0]            grant_id;
  logic                  busy;

  int n_total = 0;
  int n_pass  = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ADDR(ADDR), .BURST(BURST)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_writesig (fifo_writesig),
    .fifo_datain   (fifo_datain),
    .fifo_full     (fifo_full),
    .fifo_length   (fifo_length),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] dat [NREQ];
  int               len;
  logic             acc;
  logic [WIDTH-1:0] word;
  logic             w;
  logic             rd;

  initial begin
    dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'h32; dat[3] = 8'h43;
    rst = 1'b1; req_valid = '0; fifo_full = 1'b0; fifo_length = '0;
    req_data = {dat[3], dat[2], dat[1], dat[0]};
    tick(); tick();
    check("rst_writesig", 32'(fifo_writesig), 0);
    check("rst_datain",   32'(fifo_datain), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_busy",     32'(busy), 0);
    req_valid = 4'hF;
    #1;
    check("rst_ready", 32'(req_ready), 0);

    // Round robin over all four requesters, four beats each.
    rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("rr_busy_arb",  32'(busy), 1);
      check("rr_grant_id",  32'(grant_id), 32'(g % 4));
      check("rr_no_wr_arb", 32'(fifo_writesig), 0);
      for (int b = 0; b < BURST; b++) begin
        check("rr_ready", 32'(req_ready), 32'(1 << (g % 4)));
        tick();
        check("rr_wr",   32'(fifo_writesig), 1);
        check("rr_data", 32'(fifo_datain), 32'(dat[g % 4]));
        check("rr_busy_beat", 32'(busy), (b < BURST-1) ? 1 : 0);
      end
    end
    req_valid = '0;
    tick();
    check("idle_busy", 32'(busy), 0);

    // Single requester 2 with 8'hA5 for two transfers, then drops.
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    tick();
    check("r2_grant", 32'(grant_id), 2);
    check("r2_ready", 32'(req_ready), 32'b0100);
    tick();
    check("r2_wr1",   32'(fifo_writesig), 1);
    check("r2_data1", 32'(fifo_datain), 32'hA5);
    tick();
    check("r2_wr2",   32'(fifo_writesig), 1);
    check("r2_data2", 32'(fifo_datain), 32'hA5);
    req_valid = '0;
    tick();
    check("r2_idle",  32'(busy), 0);
    check("r2_nowr",  32'(fifo_writesig), 0);
    check("r2_hold",  32'(fifo_datain), 32'hA5);
    req_data[23:16] = dat[2];

    // One slot left: exactly one write, then wait for the drain.
    fifo_length = 5'd15;
    req_valid = 4'b0010;
    tick();
    check("cr_grant", 32'(grant_id), 1);
    check("cr_ready", 32'(req_ready), 32'b0010);
    tick();
    check("cr_wr",    32'(fifo_writesig), 1);
    check("cr_data",  32'(fifo_datain), 32'(dat[1]));
    check("cr_ready_inflight", 32'(req_ready), 0);
    tick();
    fifo_length = 5'd16; fifo_full = 1'b1;
    #1;
    check("cr_nowr",  32'(fifo_writesig), 0);
    check("cr_ready_full", 32'(req_ready), 0);
    tick();
    check("cr_nowr2", 32'(fifo_writesig), 0);
    check("cr_busy",  32'(busy), 1);
    fifo_length = 5'd15; fifo_full = 1'b0;
    #1;
    check("cr_ready_drain", 32'(req_ready), 32'b0010);
    req_valid = '0;
    tick();
    check("cr_idle", 32'(busy), 0);
    check("cr_nowr3", 32'(fifo_writesig), 0);
    fifo_length = '0;

    // FIFO full: grant held, no beats counted, full burst once released.
    fifo_full = 1'b1;
    req_valid = 4'b0001;
    tick();
    check("fu_grant", 32'(grant_id), 0);
    for (int k = 0; k < 3; k++) begin
      check("fu_ready", 32'(req_ready), 0);
      tick();
      check("fu_busy", 32'(busy), 1);
      check("fu_nowr", 32'(fifo_writesig), 0);
    end
    fifo_full = 1'b0;
    #1;
    check("fu_ready_rel", 32'(req_ready), 32'b0001);
    for (int b = 0; b < BURST; b++) begin
      tick();
      check("fu_wr", 32'(fifo_writesig), 1);
      check("fu_busy_beat", 32'(busy), (b < BURST-1) ? 1 : 0);
    end
    req_valid = '0;
    tick();

    // Reset in the second beat of a grant to requester 3.
    req_valid = 4'b1000;
    tick();
    check("rs_grant", 32'(grant_id), 3);
    tick();
    check("rs_wr1", 32'(fifo_writesig), 1);
    rst = 1'b1;
    #1;
    check("rs_ready", 32'(req_ready), 0);
    tick();
    check("rs_nowr", 32'(fifo_writesig), 0);
    check("rs_idle", 32'(busy), 0);
    check("rs_data", 32'(fifo_datain), 0);
    rst = 1'b0;
    req_valid = 4'b1001;
    tick();
    check("rs_winner", 32'(grant_id), 0);
    check("rs_busy", 32'(busy), 1);
    req_valid = '0;
    tick();
    check("rs_end_idle", 32'(busy), 0);
    tick();

    // Random valid patterns against a FIFO occupancy model.
    len = 0;
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom);
      req_data  = ($urandom_range(0, 1) == 1) ? {$urandom} : req_data ^ {$urandom};
      #1;
      check("rnd_onehot", 32'($countones(req_ready) <= 1), 1);
      acc  = |(req_valid & req_ready);
      word = '0;
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i]) word = req_data[i*WIDTH +: WIDTH];
      rd = (len > 0) && ($urandom_range(0, 2) != 0);
      w  = fifo_writesig;
      tick();
      len = len + int'(w) - int'(rd);
      check("rnd_overflow", 32'(len <= 16), 1);
      check("rnd_wr", 32'(fifo_writesig), 32'(acc));
      if (acc) check("rnd_data", 32'(fifo_datain), 32'(word));
      fifo_length = (ADDR+1)'(len);
      fifo_full   = (len == 16);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
